// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: splits word/half/byte requests into little-endian byte beats.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses with resp_err.
module lsu_byte_master #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t              state_q, state_d;
  logic                write_q, signed_q, err_q;
  logic [1:0]          size_q, cnt_q, last_q, prev_lane;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q, asm_q;
  logic                bad, last_beat;
  logic [1:0]          req_last;

  always_comb begin
    bad = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b00 && req_addr[1:0] != 2'b00);
`endif
    unique case (req_size)
      2'b00:   req_last = 2'd3;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd0;
    endcase
    last_beat = (cnt_q == last_q);
    prev_lane = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = bad ? RESP : ACCESS;
      ACCESS:  if (last_beat) state_d = write_q ? RESP : DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // addr_q/wdata_q advance per beat so the memory port is driven straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          write_q  <= req_write;
          signed_q <= req_signed;
          err_q    <= bad;
          size_q   <= req_size;
          cnt_q    <= '0;
          last_q   <= req_last;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          asm_q    <= '0;
        end
        ACCESS: begin
          addr_q  <= addr_q + ADDR_W'(1);
          wdata_q <= {8'h00, wdata_q[31:8]};
          cnt_q   <= cnt_q + 2'd1;
          // Read data lags its beat by one cycle, so lane i lands during beat i+1.
          if (!write_q && cnt_q != 2'd0) asm_q[{prev_lane, 3'b000} +: 8] <= mem_rdata;
        end
        DRAIN: asm_q[{last_q, 3'b000} +: 8] <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    mem_en     = (state_q == ACCESS);
    mem_we     = mem_en && write_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q[7:0];
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = '0;
    if (resp_valid && !err_q && !write_q) begin
      unique case (size_q)
        2'b10:   resp_rdata = {{24{signed_q & asm_q[7]}}, asm_q[7:0]};
        2'b01:   resp_rdata = {{16{signed_q & asm_q[15]}}, asm_q[15:0]};
        default: resp_rdata = asm_q;
      endcase
    end
  end

endmodule
